bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD counter with up/down direction, parallel load and wrap-or-saturate terminal behaviour. It is the successor to the fixed 4-digit up-only BCD counter, for timer, event-count and display-drive paths that need variable digit count, countdown and preset. It exports per-digit advance strobes for downstream digit-enable and cascade logic, a terminal-count flag and a load-error flag.

---
 rtl/bcd_updown_counter_if.sv | 45 ++++
 rtl/bcd_updown_counter.sv | 125 ++++++++++++
 tb/tb_bcd_updown_counter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter_if
// Description : Control/status bundle for bcd_updown_counter. Carries the
//               count requests, the preset value, the registered count and
//               the per-digit advance strobes / terminal / load-error flags.
//               master : drives enable, up, load, load_value
//               slave  : drives count, digit_ena, tc, load_err
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  enable;      // count-advance request
    logic                  up;          // 1 = increment, 0 = decrement
    logic                  load;        // parallel-load request
    logic [4*DIGITS-1:0]   load_value;  // BCD preset
    logic [4*DIGITS-1:0]   count;       // registered BCD count
    logic [DIGITS-1:0]     digit_ena;   // digit i changes at next edge
    logic                  tc;          // terminal count flag
    logic                  load_err;    // one-cycle rejected-load pulse

    modport master (
        output enable,
        output up,
        output load,
        output load_value,
        input  count,
        input  digit_ena,
        input  tc,
        input  load_err
    );

    modport slave (
        input  enable,
        input  up,
        input  load,
        input  load_value,
        output count,
        output digit_ena,
        output tc,
        output load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : Parametrised multi-digit BCD up/down counter with parallel
//               load, wrap-or-saturate terminal behaviour, per-digit advance
//               strobes, terminal-count flag and load-error pulse.
// Parameters  : DIGITS (1..8) number of BCD digits, digit 0 at bits [3:0]
//               WRAP   1 = wrap at terminal value, 0 = saturate
// Ports       : clk    rising-edge clock
//               rst_n  synchronous active-low reset
//               bus    bcd_updown_counter_if slave modport
//                      (enable, up, load, load_value -> count, digit_ena,
//                       tc, load_err)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    bcd_updown_counter_if.slave   bus
);

    localparam int c_WIDTH = 4 * DIGITS;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_WIDTH-1:0] r_count;
    logic               r_load_err;

    // ------------------------------------------------------------------
    // Per-digit decode
    // ------------------------------------------------------------------
    logic [3:0]         w_digit      [DIGITS];
    logic [3:0]         w_digit_step [DIGITS];
    logic [DIGITS-1:0]  w_is_nine;
    logic [DIGITS-1:0]  w_is_zero;
    logic [DIGITS-1:0]  w_nib_ok;
    logic [DIGITS-1:0]  w_digit_ena;
    logic [c_WIDTH-1:0] w_count_next;

    logic               w_active;
    logic               w_all_term;
    logic               w_sat_block;
    logic               w_load_ok;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_digit[i]   = r_count[4*i +: 4];
            assign w_is_nine[i] = (w_digit[i] == 4'd9);
            assign w_is_zero[i] = (w_digit[i] == 4'd0);
            assign w_nib_ok[i]  = (bus.load_value[4*i +: 4] <= 4'd9);

            // Single-digit step: 9 rolls to 0 going up, 0 rolls to 9 going
            // down. Whether the digit actually moves is decided by the
            // carry/borrow chain below.
            assign w_digit_step[i] = bus.up
                                   ? (w_is_nine[i] ? 4'd0 : w_digit[i] + 4'd1)
                                   : (w_is_zero[i] ? 4'd9 : w_digit[i] - 4'd1);

            assign w_count_next[4*i +: 4] = w_digit_ena[i] ? w_digit_step[i]
                                                           : w_digit[i];
        end
    endgenerate

    // A count step is requested only when not in reset and not loading.
    assign w_active    = bus.enable & ~bus.load & rst_n;

    // Every digit sits at the terminal value for the current direction.
    assign w_all_term  = bus.up ? (&w_is_nine) : (&w_is_zero);

    // In saturate mode the terminal value is sticky in the current direction.
    assign w_sat_block = ~WRAP & w_all_term;

    assign w_load_ok   = &w_nib_ok;

    // ------------------------------------------------------------------
    // Carry / borrow chain: digit i advances when every lower digit is at
    // its roll-over value for the current direction.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_ena
            if (i == 0) begin : g_lsd
                assign w_digit_ena[i] = w_active & ~w_sat_block;
            end else begin : g_upper
                assign w_digit_ena[i] = w_digit_ena[i-1] &
                                        (bus.up ? w_is_nine[i-1]
                                                : w_is_zero[i-1]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers: reset, then load, then count, then hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            if (w_load_ok) begin
                r_count    <= bus.load_value;
                r_load_err <= 1'b0;
            end else begin
                // Reject the whole preset; no partial load.
                r_load_err <= 1'b1;
            end
        end else begin
            r_count    <= w_count_next;
            r_load_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count     = r_count;
    assign bus.load_err  = r_load_err;
    assign bus.digit_ena = w_digit_ena;
    assign bus.tc        = w_active & w_all_term;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter
// Description : Directed self-checking bench for bcd_updown_counter. Four
//               instances share one clock and reset:
//                 ifa : DIGITS=4, WRAP=1
//                 ifs : DIGITS=4, WRAP=0
//                 if1 : DIGITS=1, WRAP=1
//                 if6 : DIGITS=6, WRAP=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(4)) ifa ();
    bcd_updown_counter_if #(.DIGITS(4)) ifs ();
    bcd_updown_counter_if #(.DIGITS(1)) if1 ();
    bcd_updown_counter_if #(.DIGITS(6)) if6 ();

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));
    bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_dut_1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_updown_counter #(.DIGITS(6), .WRAP(1'b1)) u_dut_6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [31:0] x, input int nd);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < nd; d++) begin
            if (x[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v;

        ifa.enable = 0; ifa.up = 0; ifa.load = 0; ifa.load_value = '0;
        ifs.enable = 0; ifs.up = 0; ifs.load = 0; ifs.load_value = '0;
        if1.enable = 0; if1.up = 0; if1.load = 0; if1.load_value = '0;
        if6.enable = 0; if6.up = 0; if6.load = 0; if6.load_value = '0;

        // ---------------- Reset: flags gated while rst_n=0 ----------------
        ifa.enable = 1; ifa.up = 0;
        #1;
        check("rst_tc",        32'(ifa.tc),        32'd0);
        check("rst_digit_ena", 32'(ifa.digit_ena), 32'd0);
        tick();
        check("rst_count",     32'(ifa.count),     32'h0000);
        check("rst_load_err",  32'(ifa.load_err),  32'd0);
        ifa.enable = 0;
        rst_n = 1;

        // ---------------- Reset mid-count ----------------
        ifa.load = 1; ifa.load_value = 16'h0457;
        tick();
        ifa.load = 0;
        check("load_0457", 32'(ifa.count), 32'h0457);
        ifa.enable = 1; ifa.up = 1;
        tick();
        check("step_0458", 32'(ifa.count), 32'h0458);
        rst_n = 0;
        tick();
        check("midrst_count",    32'(ifa.count),    32'h0000);
        check("midrst_load_err", 32'(ifa.load_err), 32'd0);
        rst_n = 1;
        tick();
        check("resume_0001", 32'(ifa.count), 32'h0001);
        ifa.enable = 0;

        // ---------------- Up ripple ----------------
        ifa.load = 1; ifa.load_value = 16'h0999;
        tick();
        ifa.load = 0; ifa.enable = 1; ifa.up = 1;
        #1;
        check("upripple_ena", 32'(ifa.digit_ena), 32'hF);
        check("upripple_tc",  32'(ifa.tc),        32'd0);
        tick();
        ifa.enable = 0;
        check("upripple_count", 32'(ifa.count), 32'h1000);

        // ---------------- Down borrow ----------------
        ifa.load = 1; ifa.load_value = 16'h1000;
        tick();
        ifa.load = 0; ifa.enable = 1; ifa.up = 0;
        #1;
        check("dnborrow_ena", 32'(ifa.digit_ena), 32'hF);
        check("dnborrow_tc",  32'(ifa.tc),        32'd0);
        tick();
        ifa.enable = 0;
        check("dnborrow_count", 32'(ifa.count), 32'h0999);

        // ---------------- Down wrap ----------------
        ifa.load = 1; ifa.load_value = 16'h0000;
        tick();
        ifa.load = 0; ifa.enable = 1; ifa.up = 0;
        #1;
        check("dnwrap_tc",  32'(ifa.tc),        32'd1);
        check("dnwrap_ena", 32'(ifa.digit_ena), 32'hF);
        tick();
        check("dnwrap_count", 32'(ifa.count), 32'h9999);

        // ---------------- Up wrap, then same-cycle direction changes -------
        ifa.up = 1;
        #1;
        check("upwrap_tc", 32'(ifa.tc), 32'd1);
        tick();
        check("upwrap_count", 32'(ifa.count), 32'h0000);
        tick();
        check("dir_up_0001", 32'(ifa.count), 32'h0001);
        ifa.up = 0;
        #1;
        check("dir_dn_ena", 32'(ifa.digit_ena), 32'h1);
        tick();
        check("dir_dn_0000", 32'(ifa.count), 32'h0000);
        ifa.enable = 0;
        #1;
        check("idle_tc", 32'(ifa.tc), 32'd0);

        // ---------------- Bad load ----------------
        ifa.load = 1; ifa.load_value = 16'h0042;
        tick();
        ifa.load_value = 16'h12A4;
        tick();
        ifa.load = 0;
        check("badload_count", 32'(ifa.count),    32'h0042);
        check("badload_err",   32'(ifa.load_err), 32'd1);
        tick();
        check("badload_err_clr", 32'(ifa.load_err), 32'd0);
        check("badload_hold",    32'(ifa.count),    32'h0042);

        // ---------------- Load over enable ----------------
        ifa.load = 1; ifa.load_value = 16'h0305; ifa.enable = 1; ifa.up = 1;
        #1;
        check("ldpri_ena", 32'(ifa.digit_ena), 32'h0);
        check("ldpri_tc",  32'(ifa.tc),        32'd0);
        tick();
        ifa.load = 0; ifa.enable = 0;
        check("ldpri_count",    32'(ifa.count),    32'h0305);
        check("ldpri_load_err", 32'(ifa.load_err), 32'd0);

        // ---------------- Saturate (WRAP=0) ----------------
        ifs.load = 1; ifs.load_value = 16'h9998;
        tick();
        ifs.load = 0; ifs.enable = 1; ifs.up = 1;
        #1;
        check("sat_c1_tc",  32'(ifs.tc),        32'd0);
        check("sat_c1_ena", 32'(ifs.digit_ena), 32'h1);
        tick();
        check("sat_c1_count", 32'(ifs.count), 32'h9999);
        for (int c = 2; c <= 3; c++) begin
            check($sformatf("sat_c%0d_tc", c),  32'(ifs.tc),        32'd1);
            check($sformatf("sat_c%0d_ena", c), 32'(ifs.digit_ena), 32'h0);
            tick();
            check($sformatf("sat_c%0d_count", c), 32'(ifs.count), 32'h9999);
        end
        ifs.up = 0;
        ifs.load = 1; ifs.load_value = 16'h0000;
        tick();
        ifs.load = 0;
        #1;
        check("satdn_tc",  32'(ifs.tc),        32'd1);
        check("satdn_ena", 32'(ifs.digit_ena), 32'h0);
        tick();
        ifs.enable = 0;
        check("satdn_count", 32'(ifs.count), 32'h0000);

        // ---------------- Sweep DIGITS=1 ----------------
        v = 0;
        if1.load = 1; if1.load_value = 4'h0;
        tick();
        if1.load = 0; if1.enable = 1; if1.up = 1;
        for (int s = 0; s < 25; s++) begin
            tick();
            v = (v + 1) % 10;
            check("d1_up",     32'(if1.count), to_bcd(v, 1));
            check("d1_up_bcd", 32'(nibbles_ok(32'(if1.count), 1)), 32'd1);
        end
        if1.up = 0;
        for (int s = 0; s < 25; s++) begin
            tick();
            v = (v + 9) % 10;
            check("d1_dn",     32'(if1.count), to_bcd(v, 1));
            check("d1_dn_bcd", 32'(nibbles_ok(32'(if1.count), 1)), 32'd1);
        end
        if1.enable = 0;

        // ---------------- Sweep DIGITS=6 across the wrap point ----------------
        v = 999990;
        if6.load = 1; if6.load_value = 24'h999990;
        tick();
        if6.load = 0; if6.enable = 1; if6.up = 1;
        for (int s = 0; s < 20; s++) begin
            tick();
            v = (v + 1) % 1000000;
            check("d6_up",     32'(if6.count), to_bcd(v, 6));
            check("d6_up_bcd", 32'(nibbles_ok(32'(if6.count), 6)), 32'd1);
        end
        if6.up = 0;
        for (int s = 0; s < 20; s++) begin
            tick();
            v = (v + 999999) % 1000000;
            check("d6_dn",     32'(if6.count), to_bcd(v, 6));
            check("d6_dn_bcd", 32'(nibbles_ok(32'(if6.count), 6)), 32'd1);
        end
        if6.enable = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
